// File: rtl/load_store_unit_if.sv
// Core-request and data-memory bus signals of the load/store unit.
// The LSU connects through the slave modport; the core/bus side uses master.
interface load_store_unit_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              req_valid;
    logic              MemRW;
    logic [2:0]        Size;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic              stall;
    logic              done;
    logic              err;
    logic [DWIDTH-1:0] rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_ack;
    logic [DWIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, MemRW, Size, addr, wdata, mem_ack, mem_rdata,
        input  stall, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, MemRW, Size, addr, wdata, mem_ack, mem_rdata,
        output stall, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-memory access unit: word-aligned byte-enabled bus beats, misaligned
// accesses split into two beats, sign/zero-extended load data, core stall.
module load_store_unit #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave lsu_io
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] buf_q, buf_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]          src_size;
    logic [AWIDTH-1:0]   src_addr;
    logic [DWIDTH-1:0]   src_wdata;
    logic [7:0]          be_wide;
    logic [2*DWIDTH-1:0] wd_wide;
    logic [AWIDTH-1:0]   word0, word1;
    logic [DWIDTH-1:0]   load_merged;
    logic [1:0]          pos;
    logic                last_ack;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010) ||
               (sz == 3'b100) || (sz == 3'b101);
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] sz);
        case (sz[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] extend(input logic [2:0] sz, input logic [DWIDTH-1:0] b);
        case (sz)
            3'b000:  return {{(DWIDTH-8){b[7]}}, b[7:0]};
            3'b001:  return {{(DWIDTH-16){b[15]}}, b[15:0]};
            3'b100:  return {{(DWIDTH-8){1'b0}}, b[7:0]};
            3'b101:  return {{(DWIDTH-16){1'b0}}, b[15:0]};
            default: return b;
        endcase
    endfunction

    // Beat geometry: the low nibble/word is beat 0, the high nibble/word is beat 1.
    // In IDLE it is taken from the live request so beat 0 can launch at acceptance.
    always_comb begin
        src_size  = (state_q == IDLE) ? lsu_io.Size  : size_q;
        src_addr  = (state_q == IDLE) ? lsu_io.addr  : addr_q;
        src_wdata = (state_q == IDLE) ? lsu_io.wdata : wdata_q;
        be_wide   = {4'b0000, size_mask(src_size)} << src_addr[1:0];
        wd_wide   = {{DWIDTH{1'b0}}, src_wdata} << {src_addr[1:0], 3'b000};
        word0     = {src_addr[AWIDTH-1:2], 2'b00};
        word1     = word0 + AWIDTH'(4);
    end

    // Byte for lane i lands at (i - o) mod 4, which covers both beats.
    always_comb begin
        load_merged = buf_q;
        pos         = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            pos = 2'(i) - addr_q[1:0];
            if (mem_be_q[i]) begin
                load_merged[{pos, 3'b000} +: 8] = lsu_io.mem_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        last_ack    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lsu_io.req_valid) begin
                    we_d    = lsu_io.MemRW;
                    size_d  = lsu_io.Size;
                    addr_d  = lsu_io.addr;
                    wdata_d = lsu_io.wdata;
                    buf_d   = '0;
                    if (!size_legal(lsu_io.Size)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_io.MemRW;
                        mem_addr_d  = word0;
                        mem_be_d    = be_wide[3:0];
                        mem_wdata_d = lsu_io.MemRW ? wd_wide[DWIDTH-1:0] : '0;
                    end
                end
            end
            BEAT0: begin
                if (lsu_io.mem_ack) begin
                    buf_d = load_merged;
                    if (|be_wide[7:4]) begin
                        state_d     = BEAT1;
                        mem_addr_d  = word1;
                        mem_be_d    = be_wide[7:4];
                        mem_wdata_d = we_q ? wd_wide[2*DWIDTH-1:DWIDTH] : '0;
                    end else begin
                        last_ack = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (lsu_io.mem_ack) begin
                    buf_d    = load_merged;
                    last_ack = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // rdata is written at the final ack so it is already valid during done.
        if (last_ack) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
            if (!we_q) begin
                rdata_d = extend(size_q, load_merged);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            buf_q       <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign lsu_io.done      = (state_q == RESP);
    assign lsu_io.err       = lsu_io.done & err_q;
    assign lsu_io.stall     = lsu_io.req_valid & ~lsu_io.done;
    assign lsu_io.rdata     = rdata_q;
    assign lsu_io.mem_req   = mem_req_q;
    assign lsu_io.mem_we    = mem_we_q;
    assign lsu_io.mem_addr  = mem_addr_q;
    assign lsu_io.mem_be    = mem_be_q;
    assign lsu_io.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus beats and completions are
// queued by each test and consumed by a bus responder/monitor.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.AWIDTH(32), .DWIDTH(32)) lsu_if ();

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_io (lsu_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } res_t;

    beat_t       beat_q[$];
    res_t        res_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          resp_en;
    int          waits;
    logic [31:0] last_rdata;

    task automatic exp_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                            input logic [31:0] wd, input logic [31:0] rd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.rdata = rd;
        beat_q.push_back(b);
    endtask

    task automatic exp_res(input logic e, input logic [31:0] rd);
        res_t r;
        r.err = e; r.rdata = rd;
        res_q.push_back(r);
    endtask

    // Bus responder (acks after 'waits' cycles, checks beats and stability) and completion monitor.
    task automatic bus_monitor();
        beat_t       b;
        res_t        r;
        int          cnt = 0;
        logic [68:0] snap;
        logic [68:0] cur;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                lsu_if.mem_ack   = 1'b0;
                lsu_if.mem_rdata = $urandom;
                if (lsu_if.mem_req === 1'b1) begin
                    cur = {lsu_if.mem_we, lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_wdata};
                    if (cnt == 0) begin
                        snap = cur;
                    end else begin
                        checks++;
                        if (cur !== snap) begin
                            failures++;
                            $display("FAIL bus_stable: got %h expected %h", cur, snap);
                        end
                    end
                    if (cnt >= waits) begin
                        cnt = 0;
                        checks++;
                        if (beat_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_beat: got addr=%h be=%b expected no beat",
                                     lsu_if.mem_addr, lsu_if.mem_be);
                        end else begin
                            b = beat_q.pop_front();
                            m = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
                            if (lsu_if.mem_addr !== b.addr || lsu_if.mem_be !== b.be ||
                                lsu_if.mem_we !== b.we ||
                                (b.we && ((lsu_if.mem_wdata & m) !== (b.wdata & m)))) begin
                                failures++;
                                $display("FAIL beat: got addr=%h be=%b we=%b wdata=%h expected addr=%h be=%b we=%b wdata=%h",
                                         lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_we, lsu_if.mem_wdata,
                                         b.addr, b.be, b.we, b.wdata);
                            end
                            lsu_if.mem_rdata = b.rdata;
                        end
                        lsu_if.mem_ack = 1'b1;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
            if (lsu_if.done === 1'b1) begin
                checks++;
                if (res_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done=1 err=%b expected no completion", lsu_if.err);
                end else begin
                    r = res_q.pop_front();
                    if (lsu_if.err !== r.err || lsu_if.rdata !== r.rdata) begin
                        failures++;
                        $display("FAIL result: got err=%b rdata=%h expected err=%b rdata=%h",
                                 lsu_if.err, lsu_if.rdata, r.err, r.rdata);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        lsu_if.MemRW     = we;
        lsu_if.Size      = sz;
        lsu_if.addr      = a;
        lsu_if.wdata     = wd;
        lsu_if.req_valid = 1'b1;
    endtask

    // Issues one request; done_cyc is -1 if no done arrives within the budget.
    task automatic run_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int done_cyc, output bit stall_gap,
                           output bit saw_req);
        @(negedge clk);
        drive(we, sz, a, wd);
        done_cyc  = -1;
        stall_gap = 1'b0;
        saw_req   = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (lsu_if.mem_req === 1'b1) saw_req = 1'b1;
            if (lsu_if.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (lsu_if.stall !== 1'b1) stall_gap = 1'b1;
        end
        lsu_if.req_valid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        checks++;
        if (beat_q.size() != 0 || res_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: got beats=%0d results=%0d pending expected 0 0",
                     name, beat_q.size(), res_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({lsu_if.mem_req, lsu_if.mem_we, lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_wdata,
             lsu_if.done, lsu_if.err, lsu_if.rdata, lsu_if.stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h done=%b err=%b rdata=%h stall=%b expected all 0",
                     lsu_if.mem_req, lsu_if.mem_we, lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_wdata,
                     lsu_if.done, lsu_if.err, lsu_if.rdata, lsu_if.stall);
        end
        rst = 1'b0;
        last_rdata = 32'h0;
    endtask

    task automatic test_aligned_lw();
        int dc; bit sg, sr;
        waits = 0;
        exp_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
        exp_res(1'b0, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 2) begin failures++; $display("FAIL lw_latency: got %0d expected 2", dc); end
        last_rdata = 32'hDEADBEEF;
        check_drained("lw");
    endtask

    task automatic test_lb_lbu();
        int dc; bit sg, sr;
        waits = 0;
        exp_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80123456);
        exp_res(1'b0, 32'hFFFFFF80);
        run_req(1'b0, 3'b000, 32'h103, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 2) begin failures++; $display("FAIL lb_latency: got %0d expected 2", dc); end
        exp_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80123456);
        exp_res(1'b0, 32'h00000080);
        run_req(1'b0, 3'b100, 32'h103, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 2) begin failures++; $display("FAIL lbu_latency: got %0d expected 2", dc); end
        last_rdata = 32'h00000080;
        check_drained("lb_lbu");
    endtask

    task automatic test_misaligned_sw();
        int dc; bit sg, sr;
        waits = 0;
        exp_beat(32'h100, 4'b1100, 1'b1, 32'h33440000, 32'h0);
        exp_beat(32'h104, 4'b0011, 1'b1, 32'h00001122, 32'h0);
        exp_res(1'b0, last_rdata);
        run_req(1'b1, 3'b010, 32'h102, 32'h11223344, dc, sg, sr);
        checks++;
        if (dc !== 3) begin failures++; $display("FAIL sw_split_latency: got %0d expected 3", dc); end
        check_drained("sw_split");
    endtask

    task automatic test_misaligned_lh_wait();
        int dc; bit sg, sr;
        waits = 2;
        exp_beat(32'h1FC, 4'b1000, 1'b0, 32'h0, 32'hAB000000);
        exp_beat(32'h200, 4'b0001, 1'b0, 32'h0, 32'h000000CD);
        exp_res(1'b0, 32'hFFFFCDAB);
        run_req(1'b0, 3'b001, 32'h1FF, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 7) begin failures++; $display("FAIL lh_wait_latency: got %0d expected 7", dc); end
        checks++;
        if (sg !== 1'b0) begin failures++; $display("FAIL lh_stall: got stall gap=%b expected 0", sg); end
        waits = 0;
        last_rdata = 32'hFFFFCDAB;
        check_drained("lh_wait");
    endtask

    task automatic test_wrap_lw();
        int dc; bit sg, sr;
        waits = 1;
        exp_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0, 32'h2211AAAA);
        exp_beat(32'h00000000, 4'b0011, 1'b0, 32'h0, 32'h55554433);
        exp_res(1'b0, 32'h44332211);
        run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 5) begin failures++; $display("FAIL wrap_latency: got %0d expected 5", dc); end
        waits = 0;
        last_rdata = 32'h44332211;
        check_drained("wrap");
    endtask

    task automatic test_illegal();
        int dc; bit sg, sr;
        waits = 0;
        exp_res(1'b1, last_rdata);
        run_req(1'b0, 3'b011, 32'h104, 32'h0, dc, sg, sr);
        checks++;
        if (dc !== 1) begin failures++; $display("FAIL illegal_latency: got %0d expected 1", dc); end
        checks++;
        if (sr !== 1'b0) begin failures++; $display("FAIL illegal_no_req: got mem_req seen=%b expected 0", sr); end
        check_drained("illegal");
    endtask

    task automatic test_reset_mid();
        int dc; bit sg, sr;
        resp_en = 1'b0;
        lsu_if.mem_ack = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h102, 32'h11223344);
        @(negedge clk);
        checks++;
        if (lsu_if.mem_req !== 1'b1 || lsu_if.mem_be !== 4'b1100 || lsu_if.mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rstmid_beat0: got req=%b be=%b addr=%h expected 1 1100 00000100",
                     lsu_if.mem_req, lsu_if.mem_be, lsu_if.mem_addr);
        end
        lsu_if.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (lsu_if.mem_req !== 1'b1 || lsu_if.mem_be !== 4'b0011 || lsu_if.mem_addr !== 32'h104) begin
            failures++;
            $display("FAIL rstmid_beat1: got req=%b be=%b addr=%h expected 1 0011 00000104",
                     lsu_if.mem_req, lsu_if.mem_be, lsu_if.mem_addr);
        end
        lsu_if.mem_ack   = 1'b0;
        lsu_if.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({lsu_if.mem_req, lsu_if.mem_we, lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_wdata,
             lsu_if.done, lsu_if.err, lsu_if.rdata} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got req=%b we=%b addr=%h be=%b wdata=%h done=%b err=%b rdata=%h expected all 0",
                     lsu_if.mem_req, lsu_if.mem_we, lsu_if.mem_addr, lsu_if.mem_be, lsu_if.mem_wdata,
                     lsu_if.done, lsu_if.err, lsu_if.rdata);
        end
        lsu_if.mem_ack = 1'b1;
        @(negedge clk);
        lsu_if.mem_ack = 1'b0;
        checks++;
        if (lsu_if.mem_req !== 1'b0 || lsu_if.done !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: got req=%b done=%b expected 0 0", lsu_if.mem_req, lsu_if.done);
        end
        resp_en    = 1'b1;
        last_rdata = 32'h0;
        exp_beat(32'h200, 4'b0001, 1'b1, 32'h000000A5, 32'h0);
        exp_res(1'b0, 32'h0);
        run_req(1'b1, 3'b000, 32'h200, 32'h000000A5, dc, sg, sr);
        checks++;
        if (dc !== 2) begin failures++; $display("FAIL post_reset_sb: got %0d expected 2", dc); end
        check_drained("rstmid");
    endtask

    task automatic test_back_to_back();
        int d1;
        int gap;
        waits = 0;
        exp_beat(32'h300, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D);
        exp_res(1'b0, 32'h0BADF00D);
        exp_beat(32'h304, 4'b1100, 1'b1, 32'hABCD0000, 32'h0);
        exp_res(1'b0, 32'h0BADF00D);
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h300, 32'h0);
        d1 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsu_if.done === 1'b1) begin d1 = c; break; end
        end
        checks++;
        if (d1 !== 2) begin failures++; $display("FAIL b2b_first: got %0d expected 2", d1); end
        drive(1'b1, 3'b001, 32'h306, 32'h0000ABCD);
        @(negedge clk);
        checks++;
        if (lsu_if.done !== 1'b0 || lsu_if.stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_pulse: got done=%b stall=%b expected 0 1", lsu_if.done, lsu_if.stall);
        end
        gap = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (lsu_if.done === 1'b1) begin gap = c; break; end
        end
        lsu_if.req_valid = 1'b0;
        checks++;
        if (gap !== 3) begin failures++; $display("FAIL b2b_spacing: got %0d expected 3", gap); end
        last_rdata = 32'h0BADF00D;
        check_drained("b2b");
    endtask

    initial begin
        rst              = 1'b1;
        resp_en          = 1'b1;
        waits            = 0;
        last_rdata       = 32'h0;
        lsu_if.req_valid = 1'b0;
        lsu_if.MemRW     = 1'b0;
        lsu_if.Size      = 3'b000;
        lsu_if.addr      = 32'h0;
        lsu_if.wdata     = 32'h0;
        lsu_if.mem_ack   = 1'b0;
        lsu_if.mem_rdata = 32'h0;
        fork
            bus_monitor();
        join_none
        test_reset();
        test_aligned_lw();
        test_lb_lbu();
        test_misaligned_sw();
        test_misaligned_lh_wait();
        test_wrap_lw();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
